// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and a valid/ready handshake.
// The frame format (data bits, parity, stop bits) and the bit period are
// parameters. Queued bytes leave back-to-back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,   // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [DATA_BITS-1:0]                 in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic                                 tx,
  output logic                                 tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      CLKS_PER_BIT < 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 push, pop;

  // Transmitter state
  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;

  logic                 bit_done;
  logic                 stop_last;
  logic [DATA_BITS-1:0] head_data;
  logic                 head_parity;

  assign in_ready   = (level_q != LVL_W'(FIFO_DEPTH));
  assign fifo_level = level_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;

  assign push        = in_valid && in_ready;
  assign bit_done    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign stop_last   = (bit_idx_q == 4'(STOP_BITS - 1));
  assign head_data   = mem_q[rd_ptr_q];
  assign head_parity = (PARITY_MODE == 1) ? ~(^head_data) : (^head_data);

  // The head is consumed when idle, or on the very last stop-bit cycle so the
  // next start bit follows without a gap.
  assign pop = (level_q != '0) &&
               ((state_q == S_IDLE) || (state_q == S_STOP && bit_done && stop_last));

  // Next FIFO level: a simultaneous push and pop cancel out.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  // Write accepted bytes into the circular buffer.
  // NOTE: the storage array has no reset; the pointers and level define which entries are valid, so clearing the data would only cost flops.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Frame FSM; tx and tx_busy are registered from the state being served, so the line lags the pop by exactly one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_q != S_IDLE);
      case (state_q)
        S_START:  tx_q <= 1'b0;
        S_DATA:   tx_q <= shift_q[0];
        S_PARITY: tx_q <= parity_q;
        default:  tx_q <= 1'b1;
      endcase

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q   <= head_data;
            parity_q  <= head_parity;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            cnt_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 4'(DATA_BITS - 1)) begin
              bit_idx_q <= '0;
              state_q   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (stop_last) begin
              bit_idx_q <= '0;
              if (pop) begin
                shift_q  <= head_data;
                parity_q <= head_parity;
                state_q  <= S_START;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances with different frame formats, driven
// with directed and $urandom bytes, compared cycle by cycle against a
// schedule-based model (frame start = max(push+2, end of previous frame)).
module tb_uart_tx_fifo;

  localparam int N     = 4;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int TMAX  = 600;

  function automatic int db_of(int k); return (k == 3) ? 7 : 8; endfunction
  function automatic int pm_of(int k); return (k == 1) ? 2 : ((k == 2) ? 1 : 0); endfunction
  function automatic int sb_of(int k); return (k == 3) ? 2 : 1; endfunction
  function automatic int flen(int k);
    return CPB * (1 + db_of(k) + ((pm_of(k) != 0) ? 1 : 0) + sb_of(k));
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data  [N];
  logic          in_valid [N];
  logic          in_ready [N];
  logic          tx_w     [N];
  logic          busy_w   [N];
  logic [LW-1:0] lvl_w    [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DB = db_of(g);
    uart_tx_fifo #(
      .DATA_BITS(DB), .PARITY_MODE(pm_of(g)), .STOP_BITS(sb_of(g)),
      .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .in_data(in_data[g][DB-1:0]), .in_valid(in_valid[g]),
      .in_ready(in_ready[g]), .tx(tx_w[g]), .tx_busy(busy_w[g]),
      .fifo_level(lvl_w[g])
    );
  end

  // ---------------- reference model ----------------
  typedef struct { int start; logic [7:0] data; } sched_t;
  sched_t sq [N][$];
  int     last_end [N];
  int     cyc = 0;
  logic   exp_tx [N], exp_busy [N], exp_ready [N];
  int     exp_lvl [N];
  logic   acc [N];

  function automatic int pending(int k, int e);
    int n = 0;
    for (int i = 0; i < sq[k].size(); i++) if (sq[k][i].start - 1 > e) n++;
    return n;
  endfunction

  function automatic logic frame_bit(int k, logic [7:0] d, int i);
    int db = db_of(k);
    int ones = 0;
    for (int b = 0; b < db; b++) if (d[b]) ones++;
    if (i == 0) return 1'b0;
    if (i <= db) return d[i-1];
    if (i == db + 1 && pm_of(k) != 0)
      return (pm_of(k) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    sched_t ent;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        sq[k].delete();
        last_end[k] = 0;
        acc[k] = 1'b0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < N; k++) begin
        acc[k] = 1'b0;
        if (in_valid[k] && pending(k, cyc - 1) < DEPTH) begin
          ent.start = (cyc + 2 > last_end[k]) ? cyc + 2 : last_end[k];
          ent.data  = in_data[k];
          sq[k].push_back(ent);
          last_end[k] = ent.start + flen(k);
          acc[k] = 1'b1;
        end
        while (sq[k].size() > 0 && sq[k][0].start + flen(k) <= cyc) void'(sq[k].pop_front());
      end
    end
    for (int k = 0; k < N; k++) begin
      exp_tx[k]   = 1'b1;
      exp_busy[k] = 1'b0;
      for (int i = 0; i < sq[k].size(); i++)
        if (sq[k][i].start <= cyc && cyc < sq[k][i].start + flen(k)) begin
          exp_busy[k] = 1'b1;
          exp_tx[k]   = frame_bit(k, sq[k][i].data, (cyc - sq[k][i].start) / CPB);
        end
      exp_lvl[k]   = pending(k, cyc);
      exp_ready[k] = (exp_lvl[k] < DEPTH);
    end
  end

  // ---------------- stimulus driver and trace recorder ----------------
  int         errors = 0;
  int         checks = 0;
  logic [7:0] to_send [$];
  int         acc_q [$];
  int         tr_n;
  int         tr_cyc  [TMAX];
  logic       tr_tx   [TMAX];
  logic       tr_busy [TMAX];
  logic [5:0] tr_obs  [TMAX];
  logic [5:0] tr_exp  [TMAX];

  task automatic run(input int k, input int n);
    tr_n = 0;
    for (int i = 0; i < n && i < TMAX; i++) begin
      @(negedge clk);
      if (acc[k]) begin
        acc_q.push_back(cyc);
        if (to_send.size() > 0) void'(to_send.pop_front());
      end
      tr_cyc[i]  = cyc;
      tr_tx[i]   = tx_w[k];
      tr_busy[i] = busy_w[k];
      tr_obs[i]  = {tx_w[k], busy_w[k], in_ready[k], lvl_w[k]};
      tr_exp[i]  = {exp_tx[k], exp_busy[k], exp_ready[k], 3'(exp_lvl[k])};
      tr_n++;
      in_valid[k] = (to_send.size() > 0);
      in_data[k]  = (to_send.size() > 0) ? to_send[0] : 8'($urandom);
    end
  endtask

  function automatic int first_low();
    for (int i = 0; i < tr_n; i++) if (tr_tx[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < tr_n; i++) if (tr_busy[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] decode(int first, int f, int len, int db);
    logic [7:0] d = '0;
    for (int b = 0; b < db; b++) begin
      int idx = first + f * len + (1 + b) * CPB + 1;
      if (idx < tr_n) d[b] = tr_tx[idx];
    end
    return d;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin in_valid[k] = 1'b0; in_data[k] = '0; end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({tx_w[k], busy_w[k], in_ready[k], lvl_w[k]} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL reset inst=%0d got=%b%b%b%0d want=1101", k, tx_w[k], busy_w[k], in_ready[k], lvl_w[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int f;
    acc_q.delete();
    to_send.push_back(8'hA5);
    run(0, 50);
    for (int i = 0; i < tr_n; i++) begin
      checks++;
      if (tr_obs[i] !== tr_exp[i]) begin errors++; $display("FAIL basic trace cyc=%0d got=%b want=%b", tr_cyc[i], tr_obs[i], tr_exp[i]); end
    end
    f = first_low();
    checks++;
    if (f < 0 || acc_q.size() < 1 || tr_cyc[f] - acc_q[0] != 2) begin
      errors++; $display("FAIL basic latency got_first=%0d want push+2", f);
    end else begin
      for (int b = 0; b < 10; b++)
        for (int j = 0; j < CPB; j++) begin
          checks++;
          if (tr_tx[f + b*CPB + j] !== exp_bits[b]) begin
            errors++; $display("FAIL basic bit%0d got=%b want=%b", b, tr_tx[f + b*CPB + j], exp_bits[b]);
          end
        end
    end
    checks++;
    if (busy_count() != 40) begin errors++; $display("FAIL basic busy_len got=%0d want=40", busy_count()); end
  endtask

  task automatic test_parity;
    logic want [2][2] = '{'{1'b1, 1'b0}, '{1'b0, 1'b1}};  // [even/odd][byte]
    int f;
    for (int m = 0; m < 2; m++) begin
      acc_q.delete();
      to_send.push_back(8'h07);
      to_send.push_back(8'h03);
      run(1 + m, 100);
      for (int i = 0; i < tr_n; i++) begin
        checks++;
        if (tr_obs[i] !== tr_exp[i]) begin errors++; $display("FAIL parity trace inst=%0d cyc=%0d got=%b want=%b", 1+m, tr_cyc[i], tr_obs[i], tr_exp[i]); end
      end
      f = first_low();
      for (int fr = 0; fr < 2; fr++) begin
        checks++;
        if (f < 0 || tr_tx[f + fr*44 + 9*CPB + 1] !== want[m][fr]) begin
          errors++; $display("FAIL parity inst=%0d frame=%0d got=%b want=%b", 1+m, fr, (f < 0) ? 1'bx : tr_tx[f + fr*44 + 9*CPB + 1], want[m][fr]);
        end
      end
      checks++;
      if (busy_count() != 88) begin errors++; $display("FAIL parity busy_len inst=%0d got=%0d want=88", 1+m, busy_count()); end
    end
  endtask

  task automatic test_frame_7n2;
    int f;
    acc_q.delete();
    to_send.push_back(8'h55);
    run(3, 50);
    for (int i = 0; i < tr_n; i++) begin
      checks++;
      if (tr_obs[i] !== tr_exp[i]) begin errors++; $display("FAIL 7n2 trace cyc=%0d got=%b want=%b", tr_cyc[i], tr_obs[i], tr_exp[i]); end
    end
    f = first_low();
    checks++;
    if (f < 0 || decode(f, 0, 40, 7) !== 8'h55) begin
      errors++; $display("FAIL 7n2 data got=%h want=55", (f < 0) ? 8'hxx : decode(f, 0, 40, 7));
    end
    if (f >= 0) begin
      for (int j = 32; j < 40; j++) begin
        checks++;
        if (tr_tx[f + j] !== 1'b1 || tr_busy[f + j] !== 1'b1) begin
          errors++; $display("FAIL 7n2 stop cycle=%0d tx=%b busy=%b want 1 1", j, tr_tx[f+j], tr_busy[f+j]);
        end
      end
    end
    checks++;
    if (busy_count() != 40) begin errors++; $display("FAIL 7n2 busy_len got=%0d want=40", busy_count()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
    int f, run_len;
    acc_q.delete();
    for (int i = 0; i < 3; i++) to_send.push_back(bytes[i]);
    run(0, 135);
    for (int i = 0; i < tr_n; i++) begin
      checks++;
      if (tr_obs[i] !== tr_exp[i]) begin errors++; $display("FAIL b2b trace cyc=%0d got=%b want=%b", tr_cyc[i], tr_obs[i], tr_exp[i]); end
    end
    f = first_low();
    run_len = 0;
    if (f >= 0) while (f + run_len < tr_n && tr_busy[f + run_len]) run_len++;
    checks++;
    if (run_len != 120) begin errors++; $display("FAIL b2b busy_run got=%0d want=120", run_len); end
    for (int fr = 0; fr < 3; fr++) begin
      checks++;
      if (f < 0 || decode(f, fr, 40, 8) !== bytes[fr]) begin
        errors++; $display("FAIL b2b byte%0d got=%h want=%h", fr, (f < 0) ? 8'hxx : decode(f, fr, 40, 8), bytes[fr]);
      end
    end
  endtask

  task automatic test_fifo_full;
    logic [7:0] bytes [6];
    int f, max_lvl;
    acc_q.delete();
    for (int i = 0; i < 6; i++) begin bytes[i] = 8'($urandom); to_send.push_back(bytes[i]); end
    run(0, 260);
    max_lvl = 0;
    for (int i = 0; i < tr_n; i++) begin
      checks++;
      if (tr_obs[i] !== tr_exp[i]) begin errors++; $display("FAIL full trace cyc=%0d got=%b want=%b", tr_cyc[i], tr_obs[i], tr_exp[i]); end
      if (int'(tr_obs[i][2:0]) > max_lvl) max_lvl = int'(tr_obs[i][2:0]);
      if (tr_obs[i][2:0] == 3'd4) begin
        checks++;
        if (tr_obs[i][3] !== 1'b0) begin errors++; $display("FAIL full ready_at_4 cyc=%0d got=%b want=0", tr_cyc[i], tr_obs[i][3]); end
      end
    end
    checks++;
    if (max_lvl != 4) begin errors++; $display("FAIL full max_level got=%0d want=4", max_lvl); end
    checks++;
    if (acc_q.size() != 6 || acc_q[5] - acc_q[0] != 42) begin
      errors++; $display("FAIL full accepts got_n=%0d got_gap=%0d want 6 and 42", acc_q.size(), (acc_q.size() == 6) ? acc_q[5] - acc_q[0] : -1);
    end
    f = first_low();
    for (int fr = 0; fr < 6; fr++) begin
      checks++;
      if (f < 0 || decode(f, fr, 40, 8) !== bytes[fr]) begin
        errors++; $display("FAIL full byte%0d got=%h want=%h", fr, (f < 0) ? 8'hxx : decode(f, fr, 40, 8), bytes[fr]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int f, lows;
    acc_q.delete();
    to_send.push_back(8'h3C);
    to_send.push_back(8'hC3);
    to_send.push_back(8'h81);
    run(0, 60);
    checks++;
    if (tr_busy[59] !== 1'b1) begin errors++; $display("FAIL midrst precondition busy got=%b want=1", tr_busy[59]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_w[0], busy_w[0], in_ready[0], lvl_w[0]} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL midrst immediate got=%b%b%b%0d want=1101", tx_w[0], busy_w[0], in_ready[0], lvl_w[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(0, 60);
    lows = 0;
    for (int i = 0; i < tr_n; i++) begin
      checks++;
      if (tr_obs[i] !== tr_exp[i]) begin errors++; $display("FAIL midrst idle cyc=%0d got=%b want=%b", tr_cyc[i], tr_obs[i], tr_exp[i]); end
      if (tr_tx[i] == 1'b0) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL midrst leftover got_low_cycles=%0d want=0", lows); end
    to_send.push_back(8'h5A);
    run(0, 50);
    for (int i = 0; i < tr_n; i++) begin
      checks++;
      if (tr_obs[i] !== tr_exp[i]) begin errors++; $display("FAIL midrst fresh cyc=%0d got=%b want=%b", tr_cyc[i], tr_obs[i], tr_exp[i]); end
    end
    f = first_low();
    checks++;
    if (f < 0 || decode(f, 0, 40, 8) !== 8'h5A) begin
      errors++; $display("FAIL midrst fresh_byte got=%h want=5a", (f < 0) ? 8'hxx : decode(f, 0, 40, 8));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_7n2();
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed-format TX block in the alarm system.
- Frame format is configurable: data bits, parity mode and stop bits.
- Bit timing comes from an exact clock-per-bit divisor.
- Includes a small input FIFO with a valid/ready handshake, so the host can queue bytes and frames go out back-to-back without gaps.
- Sits between the alarm/control logic and the board's serial TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5-9.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal 1-2.
- CLKS_PER_BIT, 868, i_clk cycles per bit (100 MHz / 115200); legal >= 2.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2.

Ports:
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- in_data, in, DATA_BITS, byte to queue.
- in_valid, in, 1, in_data is valid this cycle.
- in_ready, out, 1, FIFO can accept (= not full).
- tx, out, 1, serial line; idles high.
- tx_busy, out, 1, a frame is in progress (start, data, parity or stop).
- fifo_level, out, $clog2(FIFO_DEPTH+1), entries currently queued.

Behaviour:
- Reset (async, i_rst_n=0):
  - tx=1, tx_busy=0, in_ready=1, fifo_level=0.
  - FIFO flushed, FSM forced to IDLE, counters cleared.
  - Applies immediately, even mid-frame.
- Handshake: push when in_valid && in_ready at a rising edge. While in_ready=0, in_data is ignored (no overwrite, no error).
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - fifo_level updates on the cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.
  - A push into a full FIFO is impossible because in_ready=0. A pop from an empty FIFO never occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: send DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles. Then go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: one bit period. Even mode: bit = XOR of the data bits. Odd mode: bit = inverted XOR.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Timing:
  - tx is registered. The start bit first appears the cycle after the pop.
  - Latency from a push accepted at cycle k into an empty, idle block: pop at k+1, tx falls at k+2.
  - Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS) cycles exactly. No cycle is dropped or added at bit boundaries.
- tx_busy: 1 from the cycle tx falls for the start bit until the last stop-bit cycle inclusive. It stays 1 continuously across back-to-back frames.
- Widths:
  - Bit-period counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - Bit index counter is 4 bits.
- in_data changing after a push has no effect on a queued or in-flight frame.
- Illegal parameter values are rejected at elaboration via a generate-time check.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, PARITY_MODE=0, STOP_BITS=1, push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy high for exactly 40 cycles; tx falls 2 cycles after the push.
2. PARITY_MODE=2, push 0x07 -> parity bit 1; push 0x03 -> parity bit 0. With PARITY_MODE=1 the same bytes give 0 and 1. Frame = 44 cycles.
3. DATA_BITS=7, STOP_BITS=2, push 0x55 -> 7 data bits 1,0,1,0,1,0,1 followed by 8 high cycles of stop; frame = 40 cycles.
4. FIFO_DEPTH=4, push 0x11, 0x22, 0x33 on consecutive cycles -> three contiguous 40-cycle frames; tx_busy stays high for 120 cycles with no idle gap; bytes sent in order.
5. FIFO_DEPTH=4, hold in_valid=1 for 6 cycles from idle -> one byte popped immediately; in_ready drops when fifo_level=4; the 6th byte is not accepted until the first stop bit finishes; no byte is lost or duplicated.
6. Assert i_rst_n=0 midway through the data bits of frame 2 of 3 -> tx=1, tx_busy=0 and fifo_level=0 in the same cycle. After release, no remaining byte is transmitted, and a fresh push of 0x5A is sent correctly.
